// File: rtl/sensor_adc_scanner.sv
// Periodic 4-channel SPI ADC scanner: one 24-bit mode-0 frame per channel,
// results published atomically once all four channels have been captured.
module sensor_adc_scanner #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned SCAN_PERIOD = 800000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [9:0] sen_ref,
    output logic [9:0] sen_1,
    output logic [9:0] sen_2,
    output logic [9:0] sen_3,
    output logic       ready,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned FRAME_W  = 24;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned BIT_W    = $clog2(FRAME_W);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned TMR_W    = $clog2(SCAN_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        NEXT_CH,
        PUBLISH
    } state_t;

    state_t               state;
    logic [TMR_W-1:0]     tmr;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [1:0]           ch;
    logic [SAMPLE_W-1:0]  shreg;
    logic [SAMPLE_W-1:0]  shadow [NUM_CH];
    logic                 tick_c;
    logic                 div_last_c;
    logic [FRAME_W-1:0]   frame_c;

    assign tick_c     = (tmr == TMR_W'(SCAN_PERIOD - 1));
    assign div_last_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Command word, bit 0 of the frame is the vector MSB: start, single-ended, channel.
    assign frame_c    = {7'b0, 2'b11, 1'b0, ch, 12'b0};

    // Free-running scan period timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (tick_c) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Scan sequencer; every output is a register of this block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            ch      <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            ready   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            sen_ref <= '0;
            sen_1   <= '0;
            sen_2   <= '0;
            sen_3   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            // A tick landing on an active scan is dropped but remembered.
            if (tick_c && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick_c && en) begin
                        state   <= CS_SETUP;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        ch      <= '0;
                        div_cnt <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mosi    <= frame_c[FRAME_W-1];
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            shreg <= {shreg[SAMPLE_W-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                                cs_n  <= 1'b1;
                                mosi  <= 1'b0;
                                state <= CS_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                mosi    <= frame_c[BIT_W'(FRAME_W - 2) - bit_cnt];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        state   <= NEXT_CH;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                NEXT_CH: begin
                    shadow[ch] <= shreg;
                    if (ch != 2'd3) begin
                        ch    <= ch + 2'd1;
                        cs_n  <= 1'b0;
                        state <= CS_SETUP;
                    end else begin
                        // Last channel goes straight to the outputs alongside the shadows.
                        sen_ref <= shadow[0];
                        sen_1   <= shadow[1];
                        sen_2   <= shadow[2];
                        sen_3   <= shreg;
                        ready   <= 1'b1;
                        state   <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_adc_scanner.sv
// Directed bench for sensor_adc_scanner with a behavioural 10-bit SPI ADC model.
module tb_sensor_adc_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, en1, rst2, en2, miso;
    logic       sclk1, mosi1, cs1, ready1, busy1, ovr1;
    logic       sclk2, mosi2, cs2, ready2, busy2, ovr2;
    logic [9:0] r1, s11, s21, s31;
    logic [9:0] r2, s12, s22, s32;

    sensor_adc_scanner #(.CLK_DIV(2), .SCAN_PERIOD(1000)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .miso(miso),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs1),
        .sen_ref(r1), .sen_1(s11), .sen_2(s21), .sen_3(s31),
        .ready(ready1), .busy(busy1), .overrun(ovr1)
    );

    sensor_adc_scanner #(.CLK_DIV(2), .SCAN_PERIOD(300)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .miso(miso),
        .sclk(sclk2), .mosi(mosi2), .cs_n(cs2),
        .sen_ref(r2), .sen_1(s12), .sen_2(s22), .sen_3(s32),
        .ready(ready2), .busy(busy2), .overrun(ovr2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC model, attached to whichever DUT is selected.
    logic       sel = 1'b0;
    logic [9:0] mval [4];
    int         mode = 0;       // 0 normal, 1 stuck-at-1, 2 stuck-at-0
    bit         chk_frames = 1'b1;
    logic [1:0] exp_ch = 2'd0;
    logic [1:0] mch = 2'd0;
    int         rises = 0;
    logic [23:0] cap = '0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;

    wire m_sclk  = sel ? sclk2  : sclk1;
    wire m_cs    = sel ? cs2    : cs1;
    wire m_mosi  = sel ? mosi2  : mosi1;
    wire m_ready = sel ? ready2 : ready1;
    wire m_rst   = sel ? rst2   : rst1;

    // ADC drives sample bits 9..0 on sclk rises 15..24 of the frame.
    function automatic logic mbit(input int k);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        if (k >= 15 && k <= 24) return mval[mch][24-k];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (prev_cs && !m_cs) begin
            rises = 0;
            cap   = '0;
            miso  = mbit(1);
        end else if (!m_cs && m_sclk && !prev_sclk) begin
            if (rises < 24) cap[23-rises] = m_mosi;
            rises++;
            if (rises == 12) mch = cap[13:12];
            miso = mbit(rises + 1);
        end
        if (!prev_cs && m_cs && chk_frames) begin
            chk("frame_rises", 64'(rises), 64'd24);
            chk("frame_mosi", 64'(cap), 64'({7'b0, 2'b11, 1'b0, exp_ch, 12'b0}));
            exp_ch++;
        end
        prev_cs   = m_cs;
        prev_sclk = m_sclk;
    end

    int cyc = 0;
    always @(posedge clk) begin
        if (!m_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic set_vals(input logic [39:0] v);
        mval[0] = v[39:30];
        mval[1] = v[29:20];
        mval[2] = v[19:10];
        mval[3] = v[9:0];
    endtask

    task automatic wait_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_ready) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cs_fall(input int budget, output int at);
        logic p;
        p  = m_cs;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (p && !m_cs) begin
                at = cyc;
                break;
            end
            p = m_cs;
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 3000 && cyc < n; i++) @(negedge clk);
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic [39:0] vals;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   at, fall;
    bit   flag;
    logic [39:0] prev_out;

    initial begin
        vecs[0] = '{mode: 2'd0, vals: {10'h155, 10'h2AA, 10'h3FF, 10'h001}, exp: {10'h155, 10'h2AA, 10'h3FF, 10'h001}};
        vecs[1] = '{mode: 2'd0, vals: {10'h000, 10'h3FF, 10'h200, 10'h1FF}, exp: {10'h000, 10'h3FF, 10'h200, 10'h1FF}};
        vecs[2] = '{mode: 2'd1, vals: {10'h000, 10'h000, 10'h000, 10'h000}, exp: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}};
        vecs[3] = '{mode: 2'd2, vals: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, exp: {10'h000, 10'h000, 10'h000, 10'h000}};
        vecs[4] = '{mode: 2'd0, vals: {10'h123, 10'h045, 10'h3C0, 10'h27E}, exp: {10'h123, 10'h045, 10'h3C0, 10'h27E}};

        rst1 = 1'b0; rst2 = 1'b0; en1 = 1'b0; en2 = 1'b0; miso = 1'b0;
        set_vals(40'h0);
        repeat (3) @(negedge clk);
        chk("reset_pins", 64'({cs1, sclk1, mosi1, ready1, busy1, ovr1}), 64'b100000);
        chk("reset_sen", 64'({r1, s11, s21, s31}), 64'h0);

        en1 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mode = int'(vecs[i].mode);
            set_vals(vecs[i].vals);
            wait_cs_fall(1100, fall);
            chk("scan_start_on_tick", 64'(fall % 1000), 64'd0);
            chk("busy_at_start", 64'(busy1), 64'd1);
            if (i == 0) chk("first_start_cyc", 64'(fall), 64'd1000);
            wait_ready(500, at);
            chk("tick_to_ready", 64'(at - fall + 1), 64'd405);
            chk("published", 64'({r1, s11, s21, s31}), 64'(vecs[i].exp));
            @(negedge clk);
            chk("ready_pulse_busy_drop", 64'({ready1, busy1}), 64'b00);
        end
        mode = 0;

        // Model changes after ch1 captured: ch0/ch1 old, ch2/ch3 new, no partial update.
        prev_out = {r1, s11, s21, s31};
        set_vals({10'h111, 10'h222, 10'h333, 10'h044});
        wait_cs_fall(1100, fall);
        wait_cs_fall(300, fall);
        wait_cs_fall(300, fall);
        set_vals({10'h2A5, 10'h15A, 10'h0F0, 10'h30C});
        flag = 1'b0;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready1) begin
                at = cyc;
                break;
            end
            if ({r1, s11, s21, s31} !== prev_out) flag = 1'b1;
        end
        chk("hold_until_publish", 64'(flag), 64'd0);
        chk("midscan_ready_seen", 64'(at > 0), 64'd1);
        chk("midscan_published", 64'({r1, s11, s21, s31}), 64'({10'h111, 10'h222, 10'h0F0, 10'h30C}));

        // en low at a tick: nothing happens; raised again: normal scan.
        en1 = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!cs1 || ready1 || busy1) flag = 1'b1;
        end
        chk("en0_tick_ignored", 64'(flag), 64'd0);
        en1 = 1'b1;
        wait_cs_fall(1100, fall);
        chk("en1_scan_start", 64'(fall % 1000), 64'd0);
        wait_ready(500, at);
        chk("en1_tick_to_ready", 64'(at - fall + 1), 64'd405);
        chk("en1_published", 64'({r1, s11, s21, s31}), 64'({10'h2A5, 10'h15A, 10'h0F0, 10'h30C}));

        // Reset during frame 2, sclk high after bit 10.
        wait_cs_fall(1100, fall);
        wait_cs_fall(300, fall);
        wait_cs_fall(300, fall);
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (rises == 11) begin
                flag = 1'b1;
                break;
            end
        end
        chk("reached_bit10", 64'({flag, sclk1}), 64'b11);
        chk_frames = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("async_reset_pins", 64'({cs1, sclk1, ready1, busy1}), 64'b1000);
        chk("async_reset_sen", 64'({r1, s11, s21, s31}), 64'h0);
        repeat (3) @(negedge clk);
        exp_ch = 2'd0;
        chk_frames = 1'b1;
        rst1 = 1'b1;
        wait_cs_fall(1100, fall);
        chk("post_reset_start", 64'(fall), 64'd1000);
        wait_ready(500, at);
        chk("post_reset_ready", 64'(at), 64'd1404);
        chk("post_reset_published", 64'({r1, s11, s21, s31}), 64'({10'h2A5, 10'h15A, 10'h0F0, 10'h30C}));

        // Short scan period instance: second tick lands mid-scan.
        @(negedge clk);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b1;
        exp_ch = 2'd0;
        set_vals({10'h155, 10'h2AA, 10'h3FF, 10'h001});
        en2 = 1'b1;
        rst2 = 1'b1;
        wait_cs_fall(400, fall);
        chk("ovr_scan_start", 64'(fall), 64'd300);
        wait_cyc(599);
        chk("ovr_before_tick", 64'(ovr2), 64'd0);
        @(negedge clk);
        chk("ovr_set", 64'({ovr2, busy2}), 64'b11);
        wait_ready(200, at);
        chk("ovr_ready_cyc", 64'(at), 64'd704);
        chk("ovr_published", 64'({r2, s12, s22, s32}), 64'({10'h155, 10'h2AA, 10'h3FF, 10'h001}));
        wait_cyc(905);
        chk("ovr_sticky_next_scan", 64'({ovr2, busy2}), 64'b11);
        chk_frames = 1'b0;
        rst2 = 1'b0;
        #1;
        chk("ovr_cleared_by_reset", 64'(ovr2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
